// File: rtl/dmem_io_responder_if.sv
// Mem-stage bus between the LEGLite core (master) and its data-memory responder (slave).
interface dmem_io_responder_if;
    logic [15:0] draddrmem;
    logic [15:0] dwdatamem;
    logic        dwriteMem;
    logic        dreadMem;
    logic [15:0] drdatamem;

    modport master (
        output draddrmem,
        output dwdatamem,
        output dwriteMem,
        output dreadMem,
        input  drdatamem
    );

    modport slave (
        input  draddrmem,
        input  dwdatamem,
        input  dwriteMem,
        input  dreadMem,
        output drdatamem
    );
endinterface

// File: rtl/dmem_io_responder.sv
// Data-memory responder: word RAM, 7-segment display register and two debounced switches.
// Reads are combinational; writes, display and switch state update on the rising clock edge.
module SwitchDebounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CW         = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db
);
    typedef enum logic {STABLE, COUNTING} debState_t;

    debState_t       state, stateNext;
    logic [CW-1:0]   cnt, cntNext;
    logic            dbNext;
    logic            syncA, syncB;

    // Two-flop synchronizer, then the debounce state, counter and output register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            syncA <= raw;
            syncB <= syncA;
            state <= stateNext;
            cnt   <= cntNext;
            db    <= dbNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        dbNext    = db;
        case (state)
            STABLE: begin
                if (syncB != db) begin
                    stateNext = COUNTING;
                    cntNext   = CW'(1);
                end
            end
            COUNTING: begin
                if (syncB == db) begin
                    stateNext = STABLE;
                    cntNext   = '0;
                end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                    dbNext    = syncB;
                    stateNext = STABLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            default: begin
                stateNext = STABLE;
                cntNext   = '0;
            end
        endcase
    end
endmodule

module dmem_io_responder #(
    parameter int AW         = 7,
    parameter int DEB_CYCLES = 16,
    parameter int CW         = 5
) (
    input  logic                clock,
    input  logic                reset,
    dmem_io_responder_if.slave  bus,
    input  logic                io_sw0,
    input  logic                io_sw1,
    output logic [6:0]          io_display,
    output logic                access_err
);
    localparam logic [15:0] DISP_ADDR = 16'hFFF0;
    localparam logic [15:0] SW0_ADDR  = 16'hFFF8;
    localparam logic [15:0] SW1_ADDR  = 16'hFFFA;

    logic [15:0]   mem [0:(1<<AW)-1];
    logic [3:0]    disp;
    logic          sw0Db, sw1Db;
    logic [AW-1:0] idx;
    logic          isRam, isDisp, isSw0, isSw1, isMapped, badAccess;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'h3F;
            4'h1: hex7seg = 7'h06;
            4'h2: hex7seg = 7'h5B;
            4'h3: hex7seg = 7'h4F;
            4'h4: hex7seg = 7'h66;
            4'h5: hex7seg = 7'h6D;
            4'h6: hex7seg = 7'h7D;
            4'h7: hex7seg = 7'h07;
            4'h8: hex7seg = 7'h7F;
            4'h9: hex7seg = 7'h6F;
            4'hA: hex7seg = 7'h77;
            4'hB: hex7seg = 7'h7C;
            4'hC: hex7seg = 7'h39;
            4'hD: hex7seg = 7'h5E;
            4'hE: hex7seg = 7'h79;
            default: hex7seg = 7'h71;
        endcase
    endfunction

    // RAM ignores address bit 0; the IO registers decode their exact addresses.
    always_comb begin
        idx       = bus.draddrmem[AW:1];
        isRam     = (bus.draddrmem[15:AW+1] == '0);
        isDisp    = (bus.draddrmem == DISP_ADDR);
        isSw0     = (bus.draddrmem == SW0_ADDR);
        isSw1     = (bus.draddrmem == SW1_ADDR);
        isMapped  = isRam | isDisp | isSw0 | isSw1;
        badAccess = ((bus.dreadMem | bus.dwriteMem) & ~isMapped)
                  | (bus.dwriteMem & (isSw0 | isSw1));
    end

    always_comb begin
        bus.drdatamem = 16'h0000;
        if (bus.dreadMem) begin
            if (isRam)       bus.drdatamem = mem[idx];
            else if (isDisp) bus.drdatamem = {12'h000, disp};
            else if (isSw0)  bus.drdatamem = {15'h0000, sw0Db};
            else if (isSw1)  bus.drdatamem = {15'h0000, sw1Db};
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (bus.dwriteMem && isRam)
            mem[idx] <= bus.dwdatamem;
    end

    // Display register, its segment pipeline stage and the sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp       <= 4'h0;
            io_display <= 7'h00;
            access_err <= 1'b0;
        end else begin
            if (bus.dwriteMem && isDisp)
                disp <= bus.dwdatamem[3:0];
            io_display <= hex7seg(disp);
            if (badAccess)
                access_err <= 1'b1;
        end
    end

    SwitchDebounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) sw0Deb (
        .clock (clock),
        .reset (reset),
        .raw   (io_sw0),
        .db    (sw0Db)
    );

    SwitchDebounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) sw1Deb (
        .clock (clock),
        .reset (reset),
        .raw   (io_sw1),
        .db    (sw1Db)
    );
endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed testbench for dmem_io_responder: RAM, display, switch debounce, access_err and reset.
module tb_dmem_io_responder;
    logic       clock;
    logic       reset;
    logic       io_sw0;
    logic       io_sw1;
    logic [6:0] io_display;
    logic       access_err;

    int testCount;
    int failCount;

    dmem_io_responder_if bus ();

    dmem_io_responder #(.AW(7), .DEB_CYCLES(16), .CW(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .io_sw0     (io_sw0),
        .io_sw1     (io_sw1),
        .io_display (io_display),
        .access_err (access_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one bus request at the falling edge and let it settle before sampling.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] data);
        @(negedge clock);
        bus.dreadMem  = rd;
        bus.dwriteMem = wr;
        bus.draddrmem = addr;
        bus.dwdatamem = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        testCount     = 0;
        failCount     = 0;
        reset         = 1'b0;
        io_sw0        = 1'b0;
        io_sw1        = 1'b0;
        bus.dreadMem  = 1'b0;
        bus.dwriteMem = 1'b0;
        bus.draddrmem = 16'h0000;
        bus.dwdatamem = 16'h0000;
        #12;
        checkOutput("reset_display", {9'h0, io_display}, 16'h0000);
        checkOutput("reset_err", {15'h0, access_err}, 16'h0000);
        checkOutput("reset_rdata", bus.drdatamem, 16'h0000);

        @(negedge clock);
        reset = 1'b1;

        applyStimulus(1'b0, 1'b1, 16'h0006, 16'hBEEF);
        applyStimulus(1'b1, 1'b0, 16'h0006, 16'h0000);
        checkOutput("ram_read_beef", bus.drdatamem, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 16'h0006, 16'h0000);
        checkOutput("ram_read_disabled", bus.drdatamem, 16'h0000);

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234);
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h5678);
        checkOutput("rw_same_cycle_old", bus.drdatamem, 16'h1234);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        checkOutput("rw_next_cycle_new", bus.drdatamem, 16'h5678);

        applyStimulus(1'b0, 1'b1, 16'h00FE, 16'hA5A5);
        applyStimulus(1'b1, 1'b0, 16'h00FE, 16'h0000);
        checkOutput("ram_top_word", bus.drdatamem, 16'hA5A5);
        applyStimulus(1'b1, 1'b0, 16'h0006, 16'h0000);
        checkOutput("ram_other_word", bus.drdatamem, 16'hBEEF);

        applyStimulus(1'b0, 1'b1, 16'hFFF0, 16'h000A);
        applyStimulus(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        checkOutput("disp_one_edge", {9'h0, io_display}, 16'h003F);
        checkOutput("disp_readback_a", bus.drdatamem, 16'h000A);
        applyStimulus(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        checkOutput("disp_two_edges_a", {9'h0, io_display}, 16'h0077);

        applyStimulus(1'b0, 1'b1, 16'hFFF0, 16'h00F3);
        applyStimulus(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        checkOutput("disp_readback_3", bus.drdatamem, 16'h0003);
        applyStimulus(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        checkOutput("disp_two_edges_3", {9'h0, io_display}, 16'h004F);
        checkOutput("no_err_yet", {15'h0, access_err}, 16'h0000);

        applyStimulus(1'b1, 1'b0, 16'hFFF8, 16'h0000);
        io_sw0 = 1'b1;
        checkOutput("sw0_edge_0", bus.drdatamem, 16'h0000);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            #1;
            checkOutput($sformatf("sw0_edge_%0d", k), bus.drdatamem,
                        (k >= 18) ? 16'h0001 : 16'h0000);
        end

        applyStimulus(1'b1, 1'b0, 16'hFFFA, 16'h0000);
        io_sw1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 9)
                io_sw1 = 1'b0;
            #1;
            checkOutput($sformatf("sw1_glitch_%0d", i), bus.drdatamem, 16'h0000);
        end

        applyStimulus(1'b1, 1'b0, 16'h8000, 16'h0000);
        checkOutput("unmapped_rdata", bus.drdatamem, 16'h0000);
        checkOutput("err_before_edge", {15'h0, access_err}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("err_after_edge", {15'h0, access_err}, 16'h0001);
        applyStimulus(1'b0, 1'b1, 16'hFFF8, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'hFFF8, 16'h0000);
        checkOutput("sw_write_ignored", bus.drdatamem, 16'h0001);
        checkOutput("err_sticky", {15'h0, access_err}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
        checkOutput("ram_limit_unmapped", bus.drdatamem, 16'h0000);

        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_display", {9'h0, io_display}, 16'h0000);
        checkOutput("async_reset_err", {15'h0, access_err}, 16'h0000);
        bus.dreadMem  = 1'b1;
        bus.draddrmem = 16'hFFF0;
        #1;
        checkOutput("async_reset_disp_reg", bus.drdatamem, 16'h0000);
        bus.draddrmem = 16'hFFF8;
        #1;
        checkOutput("async_reset_sw0", bus.drdatamem, 16'h0000);

        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 8; k++)
            @(negedge clock);
        #1;
        checkOutput("mid_debounce_sw0", bus.drdatamem, 16'h0000);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            #1;
            checkOutput($sformatf("sw0_restart_%0d", k), bus.drdatamem,
                        (k >= 18) ? 16'h0001 : 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
